minibus_master: RTL and testbench

MINIBUS_MASTER -- requirements
Module: minibus_master

---
 rtl/minibus_master.sv | 144 ++++++++++++++
 tb/tb_minibus_master.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/minibus_master.sv
// Minibus master: turns a single-cycle request into a timed address/strobe/hold
// bus cycle with programmable setup, strobe and hold widths.
module minibus_master #(
   parameter int unsigned T_SETUP  = 1,
   parameter int unsigned T_STROBE = 3,
   parameter int unsigned T_HOLD   = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        req_rd,
   input  logic [19:0] req_addr,
   input  logic [7:0]  req_wdata,
   output logic        busy,
   output logic        done,
   output logic [7:0]  rdata,
   output logic [19:0] address,
   output logic        ale,
   output logic        rw_b,
   output logic        oe,
   output logic [7:0]  data_out,
   output logic        data_oe,
   input  logic [7:0]  data_in
);

   // Counter reload values; a parameter of 0 behaves as 1 (reload of 0).
   localparam logic [3:0] SetupLd  = (T_SETUP  == 0) ? 4'd0 : 4'(T_SETUP  - 1);
   localparam logic [3:0] StrobeLd = (T_STROBE == 0) ? 4'd0 : 4'(T_STROBE - 1);
   localparam logic [3:0] HoldLd   = (T_HOLD   == 0) ? 4'd0 : 4'(T_HOLD   - 1);

   typedef enum logic [1:0] {StIdle, StSetup, StStrobe, StHold} state_e;

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        ale_q, ale_d;
   logic        oe_q, oe_d;
   logic        rw_b_q, rw_b_d;
   logic        data_oe_q, data_oe_d;
   logic [7:0]  data_out_q, data_out_d;
   logic [19:0] address_q, address_d;
   logic [7:0]  rdata_q, rdata_d;
   logic        done_q, done_d;

   // Next-state and next-output logic; outputs are computed for the state being entered
   // so every bus pin comes straight from a flop. address/rw_b/data_out double as the
   // latched operands for the whole transaction.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      ale_d      = ale_q;
      oe_d       = oe_q;
      rw_b_d     = rw_b_q;
      data_oe_d  = data_oe_q;
      data_out_d = data_out_q;
      address_d  = address_q;
      rdata_d    = rdata_q;
      done_d     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (req) begin
               state_d    = StSetup;
               cnt_d      = SetupLd;
               ale_d      = 1'b0;
               oe_d       = 1'b1;
               rw_b_d     = req_rd;
               address_d  = req_addr;
               data_out_d = req_wdata;
               data_oe_d  = ~req_rd;
            end
         end
         StSetup: begin
            if (cnt_q == 4'd0) begin
               state_d = StStrobe;
               cnt_d   = StrobeLd;
               oe_d    = ~rw_b_q;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         StStrobe: begin
            if (cnt_q == 4'd0) begin
               state_d = StHold;
               cnt_d   = HoldLd;
               ale_d   = 1'b1;
               oe_d    = 1'b1;
               if (rw_b_q) begin
                  rdata_d = data_in;
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         StHold: begin
            if (cnt_q == 4'd0) begin
               state_d   = StIdle;
               done_d    = 1'b1;
               rw_b_d    = 1'b1;
               data_oe_d = 1'b0;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State and output registers with synchronous reset; reset drops strobes immediately.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StIdle;
         cnt_q      <= 4'd0;
         ale_q      <= 1'b1;
         oe_q       <= 1'b1;
         rw_b_q     <= 1'b1;
         data_oe_q  <= 1'b0;
         data_out_q <= 8'h00;
         address_q  <= 20'h00000;
         rdata_q    <= 8'h00;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         ale_q      <= ale_d;
         oe_q       <= oe_d;
         rw_b_q     <= rw_b_d;
         data_oe_q  <= data_oe_d;
         data_out_q <= data_out_d;
         address_q  <= address_d;
         rdata_q    <= rdata_d;
         done_q     <= done_d;
      end
   end

   assign busy     = (state_q != StIdle);
   assign done     = done_q;
   assign rdata    = rdata_q;
   assign address  = address_q;
   assign ale      = ale_q;
   assign rw_b     = rw_b_q;
   assign oe       = oe_q;
   assign data_out = data_out_q;
   assign data_oe  = data_oe_q;

endmodule

// File: tb/tb_minibus_master.sv
// Bench for minibus_master: two instances (default timing and 2/5/0 timing) checked
// cycle by cycle against a waveform model derived from the setup/strobe/hold widths.
module tb_minibus_master;

   localparam int unsigned A_S = 1, A_T = 3, A_H = 1;
   localparam int unsigned B_S = 2, B_T = 5, B_H = 0;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_a, req_b, req_rd;
   logic [19:0] req_addr;
   logic [7:0]  req_wdata, data_in;

   logic        a_busy, a_done, a_ale, a_rw_b, a_oe, a_data_oe;
   logic [7:0]  a_rdata, a_data_out;
   logic [19:0] a_address;
   logic        b_busy, b_done, b_ale, b_rw_b, b_oe, b_data_oe;
   logic [7:0]  b_rdata, b_data_out;
   logic [19:0] b_address;

   int n_vec = 0;
   int n_err = 0;
   int se[2], te[2], he[2];
   logic [19:0] exp_addr[2];
   logic [7:0]  exp_dout[2];
   logic [7:0]  exp_rdata[2];

   always #5 clk = ~clk;

   minibus_master #(.T_SETUP(A_S), .T_STROBE(A_T), .T_HOLD(A_H)) u_dut_a (
      .clk(clk), .reset(reset), .req(req_a), .req_rd(req_rd), .req_addr(req_addr),
      .req_wdata(req_wdata), .busy(a_busy), .done(a_done), .rdata(a_rdata),
      .address(a_address), .ale(a_ale), .rw_b(a_rw_b), .oe(a_oe), .data_out(a_data_out),
      .data_oe(a_data_oe), .data_in(data_in)
   );

   minibus_master #(.T_SETUP(B_S), .T_STROBE(B_T), .T_HOLD(B_H)) u_dut_b (
      .clk(clk), .reset(reset), .req(req_b), .req_rd(req_rd), .req_addr(req_addr),
      .req_wdata(req_wdata), .busy(b_busy), .done(b_done), .rdata(b_rdata),
      .address(b_address), .ale(b_ale), .rw_b(b_rw_b), .oe(b_oe), .data_out(b_data_out),
      .data_oe(b_data_oe), .data_in(data_in)
   );

   typedef struct {
      int          sel;
      bit          rd;
      logic [19:0] addr;
      logic [7:0]  wd;
      logic [7:0]  din;
      bit          chain;
   } vec_t;

   vec_t vecs[6];

   function automatic logic [41:0] pack(logic busy, logic done, logic ale, logic oe,
                                        logic rw_b, logic doe, logic [7:0] dout,
                                        logic [19:0] addr, logic [7:0] rdat);
      return {busy, done, ale, oe, rw_b, doe, dout, addr, rdat};
   endfunction

   function automatic logic [41:0] obs(int sel);
      if (sel == 0)
         return pack(a_busy, a_done, a_ale, a_oe, a_rw_b, a_data_oe, a_data_out, a_address,
                     a_rdata);
      return pack(b_busy, b_done, b_ale, b_oe, b_rw_b, b_data_oe, b_data_out, b_address,
                  b_rdata);
   endfunction

   // Expected pins in cycle k (1 = first cycle after the accepting edge).
   function automatic logic [41:0] exp_vec(int sel, int k, bit rd, logic [19:0] addr,
                                           logic [7:0] wd, logic [7:0] din);
      int s, t, h, l;
      logic [7:0] rdv;
      s = se[sel];
      t = te[sel];
      h = he[sel];
      l = s + t + h + 1;
      rdv = (rd && k > s + t) ? din : exp_rdata[sel];
      return pack(k < l, k == l, (k <= s + t) ? 1'b0 : 1'b1,
                  (rd && k > s && k <= s + t) ? 1'b0 : 1'b1,
                  (k < l) ? rd : 1'b1, (!rd && k < l), wd, addr, rdv);
   endfunction

   function automatic logic [41:0] idle_vec(int sel);
      return pack(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, exp_dout[sel], exp_addr[sel],
                  exp_rdata[sel]);
   endfunction

   task automatic check(input string name, input logic [41:0] act, input logic [41:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got busy,done,ale,oe,rw_b,doe,dout,addr,rdata=%h required %h",
                  name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int sel, input logic v);
      if (sel == 0) req_a = v;
      else req_b = v;
   endtask

   task automatic clear_model();
      for (int i = 0; i < 2; i++) begin
         exp_addr[i]  = 20'h0;
         exp_dout[i]  = 8'h0;
         exp_rdata[i] = 8'h0;
      end
   endtask

   task automatic idle_chk(input string tag);
      req_a = 1'b0;
      req_b = 1'b0;
      step();
      check({tag, " idle_a"}, obs(0), idle_vec(0));
      check({tag, " idle_b"}, obs(1), idle_vec(1));
   endtask

   // Full transaction: request presented now, accepted on the next edge. While busy the
   // request line and operands are scrambled; data_in carries din only in the last
   // strobe cycle.
   task automatic run_txn(input int sel, input bit rd, input logic [19:0] addr,
                          input logic [7:0] wd, input logic [7:0] din, input string tag);
      int s, t, h, l;
      s = se[sel];
      t = te[sel];
      h = he[sel];
      l = s + t + h + 1;
      req_rd    = rd;
      req_addr  = addr;
      req_wdata = wd;
      data_in   = din ^ 8'h5A;
      set_req(sel, 1'b1);
      for (int k = 1; k <= l; k++) begin
         step();
         check($sformatf("%s k%0d", tag, k), obs(sel), exp_vec(sel, k, rd, addr, wd, din));
         if (k < l) begin
            set_req(sel, 1'($urandom_range(0, 1)));
            req_rd    = 1'($urandom);
            req_addr  = 20'($urandom);
            req_wdata = 8'($urandom);
            data_in   = (k == s + t) ? din : din ^ 8'($urandom_range(1, 255));
         end else begin
            set_req(sel, 1'b0);
         end
      end
      exp_addr[sel] = addr;
      exp_dout[sel] = wd;
      if (rd) exp_rdata[sel] = din;
   endtask

   localparam logic [41:0] RstV = {1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 20'h0, 8'h00};

   initial begin
      int sel;
      se[0] = (A_S == 0) ? 1 : A_S;
      te[0] = (A_T == 0) ? 1 : A_T;
      he[0] = (A_H == 0) ? 1 : A_H;
      se[1] = (B_S == 0) ? 1 : B_S;
      te[1] = (B_T == 0) ? 1 : B_T;
      he[1] = (B_H == 0) ? 1 : B_H;
      clear_model();

      vecs[0] = '{0, 1'b0, 20'h01234, 8'h5A, 8'h00, 1'b0};
      vecs[1] = '{0, 1'b1, 20'h02000, 8'h00, 8'hE5, 1'b0};
      vecs[2] = '{0, 1'b0, 20'h0ABCD, 8'h3C, 8'h00, 1'b1};
      vecs[3] = '{0, 1'b1, 20'h00FFF, 8'h99, 8'h81, 1'b0};
      vecs[4] = '{1, 1'b0, 20'h12345, 8'hA5, 8'h00, 1'b0};
      vecs[5] = '{1, 1'b1, 20'h54321, 8'h00, 8'h7E, 1'b0};

      // Reset with req high: reset values, request ignored.
      reset     = 1'b1;
      req_a     = 1'b1;
      req_b     = 1'b1;
      req_rd    = 1'b0;
      req_addr  = 20'hFFFFF;
      req_wdata = 8'hFF;
      data_in   = 8'h00;
      repeat (2) begin
         step();
         check("reset_a", obs(0), RstV);
         check("reset_b", obs(1), RstV);
      end
      reset = 1'b0;
      idle_chk("post_reset");

      // Reset in the second strobe cycle of a read aborts it with no done.
      req_rd    = 1'b1;
      req_addr  = 20'h0F0F0;
      req_wdata = 8'h11;
      data_in   = 8'hC3;
      req_a     = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         step();
         check($sformatf("abort k%0d", k), obs(0), exp_vec(0, k, 1'b1, 20'h0F0F0, 8'h11, 8'hC3));
         req_a = 1'b0;
      end
      reset = 1'b1;
      step();
      check("abort_reset_a", obs(0), RstV);
      check("abort_reset_b", obs(1), RstV);
      reset = 1'b0;
      clear_model();
      idle_chk("abort_after");

      // Directed table: default write, card-detect read, back-to-back pair, alt timing.
      for (int i = 0; i < 6; i++) begin
         run_txn(vecs[i].sel, vecs[i].rd, vecs[i].addr, vecs[i].wd, vecs[i].din,
                 $sformatf("vec%0d", i));
         if (!vecs[i].chain) idle_chk($sformatf("vec%0d", i));
      end

      // Randomized transactions, sometimes chained back-to-back.
      sel = 0;
      for (int i = 0; i < 30; i++) begin
         run_txn(sel, 1'($urandom), 20'($urandom), 8'($urandom), 8'($urandom),
                 $sformatf("rnd%0d", i));
         if ($urandom_range(0, 1) == 0) begin
            idle_chk($sformatf("rnd%0d", i));
            sel = int'($urandom_range(0, 1));
         end
      end
      idle_chk("final");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
